// File: rtl/i2s_rx_pkg.sv
// Shared constants and enumerations for the I2S receive path.
package i2s_pkg;

  localparam int DATA_W_DEF      = 24;
  localparam int SLOT_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_e;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } state_e;

endpackage

// File: rtl/i2s_rx_edge_sync.sv
// Pin synchronisers for bclk/lrclk/sdata, plus the bclk rise pulse and the
// LRCLK change detect evaluated on each bclk rise.
module i2s_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bclk,
  input  logic i_lrclk,
  input  logic i_sdata,
  output logic o_b_rise,
  output logic o_lr,
  output logic o_sd,
  output logic o_lr_edge
);

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lr_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_bclk_prev;
  logic                   r_lr_prev;
  logic                   r_lr_seen;
  logic                   w_b_rise;
  logic                   w_lr;

  // NOTE: synchroniser flops carry no reset; resetting them would fabricate a
  // bclk rise when reset is released while the pin is high.
  always_ff @(posedge clk) begin
    r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
    r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], i_lrclk};
    r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], i_sdata};
    r_bclk_prev <= r_bclk_sync[SYNC_STAGES-1];
  end

  assign w_b_rise = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
  assign w_lr     = r_lr_sync[SYNC_STAGES-1];

  // The first sample after reset only seeds the history; it is never an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lr_prev <= 1'b0;
      r_lr_seen <= 1'b0;
    end else if (w_b_rise) begin
      r_lr_prev <= w_lr;
      r_lr_seen <= 1'b1;
    end
  end

  assign o_b_rise  = w_b_rise;
  assign o_lr      = w_lr;
  assign o_sd      = r_sd_sync[SYNC_STAGES-1];
  assign o_lr_edge = w_b_rise & r_lr_seen & (w_lr != r_lr_prev);

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: deserialises left/right words and offers pairs on
// a valid/ready port. Define I2S_RX_LEVEL_METER_EN to add the peak level meter.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int SLOT_W      = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] out_l,
  output logic [DATA_W-1:0] out_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              err,
  input  logic              clr_flags
`ifdef I2S_RX_LEVEL_METER_EN
  ,
  output logic [DATA_W-2:0] level
`endif
);

  localparam int                   CNT_W      = $clog2(DATA_W + 1);
  localparam int                   SLOT_CNT_W = $clog2(SLOT_W + 2);
  localparam logic [CNT_W-1:0]     DATA_W_C   = CNT_W'(DATA_W);
  localparam logic [SLOT_CNT_W-1:0] SLOT_C    = SLOT_CNT_W'(SLOT_W);

  logic                  w_b_rise;
  logic                  w_lr;
  logic                  w_sd;
  logic                  w_lr_edge;

  state_e                r_state;
  chan_e                 r_chan;
  logic [DATA_W-1:0]     r_shift;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [DATA_W-1:0]     r_word_l;
  logic [DATA_W-1:0]     r_word_r;
  logic                  r_pair_pend;
  logic                  r_short_err;
  logic [SLOT_CNT_W-1:0] r_slot_cnt;
  logic                  r_slot_armed;
  logic                  r_slot_err;
  logic [DATA_W-1:0]     r_out_l;
  logic [DATA_W-1:0]     r_out_r;
  logic                  r_out_valid;
  logic                  r_overflow;
  logic                  r_err;

  logic [DATA_W-1:0]     w_shift_next;
  logic [CNT_W-1:0]      w_bitcnt_next;
  logic [CNT_W-1:0]      w_pad_bits;
  logic [DATA_W-1:0]     w_partial;
  logic                  w_latch;
  logic [DATA_W-1:0]     w_latch_val;
  logic                  w_load;
  logic                  w_drop;

  i2s_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_bclk   (bclk),
    .i_lrclk  (lrclk),
    .i_sdata  (sdata),
    .o_b_rise (w_b_rise),
    .o_lr     (w_lr),
    .o_sd     (w_sd),
    .o_lr_edge(w_lr_edge)
  );

  assign w_shift_next  = {r_shift[DATA_W-2:0], w_sd};
  assign w_bitcnt_next = r_bitcnt + 1'b1;
  assign w_pad_bits    = DATA_W_C - r_bitcnt;
  assign w_partial     = r_shift << w_pad_bits;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_latch     = 1'b0;
    w_latch_val = w_shift_next;
    if (w_b_rise && r_state == SHIFT) begin
      if (w_lr_edge) begin
        w_latch     = 1'b1;
        w_latch_val = w_partial;
      end else if (w_bitcnt_next == DATA_W_C) begin
        w_latch = 1'b1;
      end
    end
  end

  // The b_rise on which LRCLK changes is slot position 0; SKIP drops the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ALIGN;
      r_chan      <= CH_L;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_word_l    <= '0;
      r_word_r    <= '0;
      r_pair_pend <= 1'b0;
      r_short_err <= 1'b0;
    end else begin
      r_pair_pend <= 1'b0;
      r_short_err <= 1'b0;
      if (w_b_rise) begin
        case (r_state)
          ALIGN: if (w_lr_edge && !w_lr) begin
            r_state <= SKIP;
            r_chan  <= CH_L;
          end
          SKIP: if (w_lr_edge) begin
            r_chan <= chan_e'(w_lr);
          end else begin
            r_state  <= SHIFT;
            r_bitcnt <= '0;
            r_shift  <= '0;
          end
          SHIFT: if (w_lr_edge) begin
            r_short_err <= 1'b1;
            r_state     <= SKIP;
            r_chan      <= chan_e'(w_lr);
          end else begin
            r_shift  <= w_shift_next;
            r_bitcnt <= w_bitcnt_next;
            if (w_bitcnt_next == DATA_W_C) r_state <= PAD;
          end
          PAD: if (w_lr_edge) begin
            r_state <= SKIP;
            r_chan  <= chan_e'(w_lr);
          end
          default: r_state <= ALIGN;
        endcase
      end
      if (w_latch) begin
        if (r_chan == CH_L) begin
          r_word_l <= w_latch_val;
        end else begin
          r_word_r    <= w_latch_val;
          r_pair_pend <= 1'b1;
        end
      end
    end
  end

  // Slot length is judged only between two observed LRCLK edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt   <= '0;
      r_slot_armed <= 1'b0;
      r_slot_err   <= 1'b0;
    end else begin
      r_slot_err <= 1'b0;
      if (w_b_rise) begin
        if (w_lr_edge) begin
          r_slot_err   <= r_slot_armed && (r_slot_cnt != SLOT_C);
          r_slot_armed <= 1'b1;
          r_slot_cnt   <= SLOT_CNT_W'(1);
        end else if (r_slot_cnt <= SLOT_C) begin
          r_slot_cnt <= r_slot_cnt + 1'b1;
        end
      end
    end
  end

  assign w_load = r_pair_pend && (!r_out_valid || out_ready);
  assign w_drop = r_pair_pend && r_out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_l     <= '0;
      r_out_r     <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_l     <= r_word_l;
        r_out_r     <= r_word_r;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop)         r_overflow <= 1'b1;
      else if (clr_flags) r_overflow <= 1'b0;
      if (r_short_err || r_slot_err) r_err <= 1'b1;
      else if (clr_flags)            r_err <= 1'b0;
    end
  end

  assign out_l     = r_out_l;
  assign out_r     = r_out_r;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign err       = r_err;

`ifdef I2S_RX_LEVEL_METER_EN
  logic [DATA_W-2:0] r_level;
  logic [15:0]       r_decay;
  logic [DATA_W-2:0] w_mag_l;
  logic [DATA_W-2:0] w_mag_r;
  logic [DATA_W-2:0] w_level_max;

  // Magnitude of a two's-complement word; the most negative code saturates.
  function automatic logic [DATA_W-2:0] mag(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1])                             return x[DATA_W-2:0];
    else if (x == {1'b1, {(DATA_W-1){1'b0}}})     return '1;
    else                                          return neg[DATA_W-2:0];
  endfunction

  assign w_mag_l = mag(r_word_l);
  assign w_mag_r = mag(r_word_r);

  always_comb begin
    w_level_max = r_level;
    if (w_mag_l > w_level_max) w_level_max = w_mag_l;
    if (w_mag_r > w_level_max) w_level_max = w_mag_r;
  end

  // The decay timer restarts on every load so a fresh peak holds a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_decay <= '0;
    end else if (w_load) begin
      r_level <= w_level_max;
      r_decay <= '0;
    end else begin
      r_decay <= r_decay + 1'b1;
      if (&r_decay && r_level != '0) r_level <= r_level - 1'b1;
    end
  end

  assign level = r_level;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: directed frames, expected pairs queued at issue
// time and checked by an independent output monitor.
module tb_i2s_rx;

  localparam int DATA_W = 24;
  localparam int HALF   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              bclk = 1'b0;
  logic              lrclk = 1'b1;
  logic              sdata = 1'b0;
  logic              out_ready = 1'b1;
  logic              clr_flags = 1'b0;
  logic [DATA_W-1:0] out_l;
  logic [DATA_W-1:0] out_r;
  logic              out_valid;
  logic              overflow;
  logic              err;
`ifdef I2S_RX_LEVEL_METER_EN
  logic [DATA_W-2:0] level;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  pair_t sb[$];
  int    total = 0;
  int    bad   = 0;

  i2s_rx dut (
    .clk      (clk),
    .rst      (rst),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .out_l    (out_l),
    .out_r    (out_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow),
    .err      (err),
    .clr_flags(clr_flags)
`ifdef I2S_RX_LEVEL_METER_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    sb.push_back(p);
  endtask

  // One bclk period: data set up while low, then the rising edge.
  task automatic bclk_rise(input logic lr, input logic sd);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    step(HALF);
    bclk = 1'b1;
    step(HALF);
  endtask

  // Slot layout: rise 0 carries the LRCLK change, rise 1 the delay bit,
  // rises 2.. carry nbits of w MSB first, the rest pad with zero.
  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] w,
                           input int nbits, input int len, input int rst_at);
    logic b;
    for (int i = 0; i < len; i++) begin
      b = 1'b0;
      if (i >= 2 && (i - 2) < nbits) b = w[DATA_W-1-(i-2)];
      bclk_rise(lr, b);
      if (i == rst_at) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    send_slot(1'b0, l, DATA_W, 32, -1);
    send_slot(1'b1, r, DATA_W, 32, -1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      step(1);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    step(1);
  endtask

  // Output monitor: each negedge with valid && ready is one accepted pair.
  always @(negedge clk) begin : monitor
    pair_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pair: got %h/%h want none", out_l, out_r);
      end else begin
        e = sb.pop_front();
        check("pair_l", out_l, e.l);
        check("pair_r", out_r, e.r);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    step(5);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_l", out_l, 0);
    check("rst_r", out_r, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err, 0);

    // Three clean frames after a short right-channel lead-in.
    send_slot(1'b1, '0, 0, 4, -1);
    repeat (3) begin
      push(24'h123456, 24'hABCDEF);
      send_frame(24'h123456, 24'hABCDEF);
    end
    wait_drain("t1_drain");
    @(negedge clk);
    check("t1_err", err, 0);
    check("t1_ovf", overflow, 0);

    // Stimulus begins part-way through a right slot.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    send_slot(1'b1, 24'hFFFFFF, DATA_W, 14, -1);
    push(24'h654321, 24'h0FEDCB);
    send_frame(24'h654321, 24'h0FEDCB);
    wait_drain("t2_drain");
    @(negedge clk);
    check("t2_err", err, 0);

    // Back-pressure across two frames: first pair held, second dropped.
    out_ready = 1'b0;
    push(24'h000001, 24'h000002);
    send_frame(24'h000001, 24'h000002);
    send_frame(24'h000003, 24'h000004);
    @(negedge clk);
    check("t3_valid", out_valid, 1);
    check("t3_hold_l", out_l, 24'h000001);
    check("t3_hold_r", out_r, 24'h000002);
    check("t3_ovf", overflow, 1);
    out_ready = 1'b1;
    step(2);
    push(24'h000005, 24'h000006);
    send_frame(24'h000005, 24'h000006);
    wait_drain("t3_drain");
    @(negedge clk);
    check("t3_ovf_sticky", overflow, 1);
    pulse_clr();
    @(negedge clk);
    check("t3_ovf_clr", overflow, 0);
    check("t3_err", err, 0);

    // Left slot cut short after 20 bits.
    push(24'hFFFFF0, 24'h00000A);
    send_slot(1'b0, 24'hFFFFFF, 20, 22, -1);
    send_slot(1'b1, 24'h00000A, DATA_W, 32, -1);
    wait_drain("t4_drain");
    @(negedge clk);
    check("t4_err", err, 1);
    pulse_clr();
    @(negedge clk);
    check("t4_err_clr", err, 0);

    // Reset at bit 10 of a left word; the next full frame must land intact.
    send_slot(1'b0, 24'hC0FFEE, DATA_W, 32, 12);
    @(negedge clk);
    check("t5_l", out_l, 0);
    check("t5_r", out_r, 0);
    check("t5_valid", out_valid, 0);
    check("t5_err", err, 0);
    check("t5_ovf", overflow, 0);
    send_slot(1'b1, 24'h777777, DATA_W, 32, -1);
    push(24'h000001, 24'h800000);
    send_frame(24'h000001, 24'h800000);
    wait_drain("t5_drain");
    @(negedge clk);
    check("t5_err_after", err, 0);

`ifdef I2S_RX_LEVEL_METER_EN
    check("lv_after_t5", level, 23'h7FFFFF);
    push(24'h800000, 24'h000000);
    send_frame(24'h800000, 24'h000000);
    wait_drain("lv_drain");
    @(negedge clk);
    check("lv_peak", level, 23'h7FFFFF);
    step(65536 - 200);
    @(negedge clk);
    check("lv_hold", level, 23'h7FFFFF);
    step(400);
    @(negedge clk);
    check("lv_decay", level, 23'h7FFFFE);
`endif

    step(20);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
